axi_tx: RTL and testbench

Serializer stage that sits directly upstream of `axi_rx`. It accepts parallel words over a valid/ready handshake, generates the serial bit clock from the system clock, and drives `sclk`/`sdata`/`svalid` MSB-first. Back-to-back words are sent with `svalid` held continuously high, matching what `axi_rx` expects for multi-packet bursts.

---
 rtl/axi_tx_pkg.sv | 17 +
 rtl/axi_tx_sclk_gen.sv | 54 +++++
 rtl/axi_tx.sv | 102 ++++++++++
 tb/tb_axi_tx.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_tx_pkg.sv
// Shared types and width helpers for the axi_tx serializer and its sclk generator.
package axi_tx_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam int unsigned DEF_PACKET_LENGTH = 32;
    localparam int unsigned DEF_CLK_DIV       = 2;

    // A counter is at least one bit wide, even when it counts to one value.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axi_tx_sclk_gen.sv
// Serial clock generator: divides aclk by 2*clk_div and flags the edge on which sclk toggles.
module sclk_gen
    import axi_tx_pkg::*;
#(
    parameter int unsigned clk_div = DEF_CLK_DIV
) (
    input  logic aclk,
    input  logic areset,
    input  logic enable,
    output logic sclk,
    output logic rise_stb,
    output logic fall_stb
);

    localparam int unsigned        DIV_W    = cnt_width(clk_div);
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(clk_div - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             sclk_q, sclk_d;
    logic             toggle;

    // Strobes announce the toggle that the next aclk edge will perform.
    assign toggle   = enable && (div_q == DIV_LAST);
    assign rise_stb = toggle && !sclk_q;
    assign fall_stb = toggle &&  sclk_q;
    assign sclk     = sclk_q;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        div_d  = div_q;
        sclk_d = sclk_q;
        if (!enable) begin
            div_d  = '0;
            sclk_d = 1'b0;
        end else if (toggle) begin
            div_d  = '0;
            sclk_d = !sclk_q;
        end else begin
            div_d  = div_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            div_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            sclk_q <= sclk_d;
        end
    end

endmodule

// File: rtl/axi_tx.sv
// Parallel-to-serial transmitter: one-word holding register feeding an MSB-first shifter.
module axi_tx
    import axi_tx_pkg::*;
#(
    parameter int unsigned packet_length = DEF_PACKET_LENGTH,
    parameter int unsigned clk_div       = DEF_CLK_DIV
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic [packet_length-1:0] tx_data,
    input  logic                     tx_valid,
    output logic                     tx_ready,
    output logic                     sclk,
    output logic                     sdata,
    output logic                     svalid,
    output logic                     busy
);

    localparam int unsigned      BIT_W    = cnt_width(packet_length);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(packet_length - 1);

    state_e                   state_q;
    logic [packet_length-1:0] hold_q;
    logic                     hold_full_q;
    logic [packet_length-1:0] shift_q;
    logic [BIT_W-1:0]         bit_q;
    logic                     svalid_q;

    logic handshake;
    logic fall_stb;
    logic sclk_rise_unused;

    assign tx_ready  = !hold_full_q && !areset;
    assign handshake = tx_valid && tx_ready;

    sclk_gen #(
        .clk_div (clk_div)
    ) u_sclk_gen (
        .aclk     (aclk),
        .areset   (areset),
        .enable   (state_q == SHIFT),
        .sclk     (sclk),
        .rise_stb (sclk_rise_unused),
        .fall_stb (fall_stb)
    );

    // NOTE: hold_q carries no reset; it is only ever read while hold_full_q qualifies it.
    always_ff @(posedge aclk) begin
        if (handshake) begin
            hold_q <= tx_data;
        end
    end

    // tx_ready is low while hold is full, so a handshake and a load never collide on hold_full_q.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q     <= IDLE;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            bit_q       <= '0;
            svalid_q    <= 1'b0;
        end else begin
            if (handshake) begin
                hold_full_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    bit_q <= '0;
                    if (hold_full_q) begin
                        shift_q     <= hold_q;
                        hold_full_q <= 1'b0;
                        svalid_q    <= 1'b1;
                        state_q     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (fall_stb) begin
                        if (bit_q == BIT_LAST) begin
                            bit_q <= '0;
                            if (hold_full_q) begin
                                shift_q     <= hold_q;
                                hold_full_q <= 1'b0;
                            end else begin
                                shift_q  <= '0;
                                svalid_q <= 1'b0;
                                state_q  <= IDLE;
                            end
                        end else begin
                            bit_q   <= bit_q + 1'b1;
                            shift_q <= {shift_q[packet_length-2:0], 1'b0};
                        end
                    end
                end
            endcase
        end
    end

    assign sdata  = shift_q[packet_length-1];
    assign svalid = svalid_q;
    assign busy   = (state_q == SHIFT) || hold_full_q;

endmodule

// File: tb/tb_axi_tx.sv
// Bench for axi_tx: scoreboarded serial receiver on the default instance plus a clk_div=1 instance.
module tb_axi_tx;

    logic        aclk = 1'b0;
    logic        areset;
    logic [31:0] tx_data, tx_data1;
    logic        tx_valid, tx_valid1;
    logic        tx_ready, tx_ready1;
    logic        sclk, sdata, svalid, busy;
    logic        sclk1, sdata1, svalid1, busy1;

    always #5 aclk = ~aclk;

    axi_tx dut (
        .aclk     (aclk),
        .areset   (areset),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .sclk     (sclk),
        .sdata    (sdata),
        .svalid   (svalid),
        .busy     (busy)
    );

    axi_tx #(.packet_length(32), .clk_div(1)) dut1 (
        .aclk     (aclk),
        .areset   (areset),
        .tx_data  (tx_data1),
        .tx_valid (tx_valid1),
        .tx_ready (tx_ready1),
        .sclk     (sclk1),
        .sdata    (sdata1),
        .svalid   (svalid1),
        .busy     (busy1)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Receiver model: samples sdata on every rising sclk while svalid is high.
    logic [31:0] sb_q[$];
    logic [31:0] rx_sr = '0;
    logic        prev_sclk = 1'b0;
    int          rx_bits = 0, rx_words = 0, rise_total = 0;
    int          run_cnt = 0, run_rises = 0, last_run = 0, last_rises = 0;

    always @(negedge aclk) begin
        if (areset) begin
            rx_bits   = 0;
            run_cnt   = 0;
            run_rises = 0;
            prev_sclk = 1'b0;
            sb_q.delete();
        end else begin
            if (sclk && !prev_sclk) begin
                rise_total++;
                if (svalid) begin
                    rx_sr = {rx_sr[30:0], sdata};
                    rx_bits++;
                    run_rises++;
                    if (rx_bits == 32) begin
                        rx_bits = 0;
                        rx_words++;
                        if (sb_q.size() == 0) fail("unexpected_word");
                        else check("rx_word", rx_sr, sb_q.pop_front());
                    end
                end
            end
            if (svalid) begin
                run_cnt++;
            end else if (run_cnt != 0) begin
                last_run   = run_cnt;
                last_rises = run_rises;
                run_cnt    = 0;
                run_rises  = 0;
            end
            prev_sclk = sclk;
        end
    end

    // Called at a negedge; returns at the negedge after the handshake edge.
    task automatic send(input logic [31:0] w, output int waited);
        waited   = 0;
        tx_data  = w;
        tx_valid = 1'b1;
        while (!tx_ready && waited < 1000) begin
            @(negedge aclk);
            waited++;
        end
        if (!tx_ready) begin
            fail("send_handshake");
        end else begin
            sb_q.push_back(w);
            @(posedge aclk);
        end
        @(negedge aclk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 2000) begin
            @(negedge aclk);
            n++;
        end
        if (busy) fail(name);
        @(negedge aclk);
    endtask

    typedef struct {
        logic [31:0] word;
        int          run;
        int          rises;
    } vec_t;

    vec_t        vecs[4];
    int          w, words0, n;
    int          run1, rises1, first_rise;
    logic        p1;
    logic [31:0] word1;

    initial begin
        vecs[0] = '{word: 32'h0000_0000, run: 128, rises: 32};
        vecs[1] = '{word: 32'hFFFF_FFFF, run: 128, rises: 32};
        vecs[2] = '{word: 32'h8000_0001, run: 128, rises: 32};
        vecs[3] = '{word: 32'h5A5A_3C3C, run: 128, rises: 32};

        tx_data = '0; tx_valid = 1'b0; tx_data1 = '0; tx_valid1 = 1'b0;
        areset  = 1'b1;

        // Reset
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_sclk",     32'(sclk),     32'd0);
        check("rst_sdata",    32'(sdata),    32'd0);
        check("rst_svalid",   32'(svalid),   32'd0);
        check("rst_tx_ready", 32'(tx_ready), 32'd0);
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_ready1",   32'(tx_ready1), 32'd0);
        areset = 1'b0;
        @(negedge aclk);
        check("ready_after_rst", 32'(tx_ready), 32'd1);
        repeat (5) @(negedge aclk);
        check("idle_no_rises", 32'(rise_total), 32'd0);
        check("idle_sclk_low", 32'(sclk), 32'd0);

        // Single word with edge-accurate timing
        send(32'hA5C3_0F01, w);
        check("svalid_at_E",     32'(svalid), 32'd0);
        @(negedge aclk);
        check("svalid_at_E1",    32'(svalid), 32'd1);
        check("msb_at_E1",       32'(sdata),  32'd1);
        check("sclk_at_E1",      32'(sclk),   32'd0);
        @(negedge aclk);
        check("sclk_at_E2",      32'(sclk),   32'd0);
        @(negedge aclk);
        check("first_rise_E3",   32'(sclk),   32'd1);
        wait_idle("single_idle");
        check("single_run",      32'(last_run),   32'd128);
        check("single_rises",    32'(last_rises), 32'd32);

        // Table of single words
        for (int i = 0; i < 4; i++) begin
            words0 = rx_words;
            send(vecs[i].word, w);
            wait_idle("vec_idle");
            check("vec_run",   32'(last_run),          32'(vecs[i].run));
            check("vec_rises", 32'(last_rises),        32'(vecs[i].rises));
            check("vec_words", 32'(rx_words - words0), 32'd1);
        end

        // Back-to-back
        words0 = rx_words;
        send(32'hDEAD_BEEF, w);
        send(32'h1234_5678, w);
        wait_idle("b2b_idle");
        check("b2b_run",   32'(last_run),          32'd256);
        check("b2b_rises", 32'(last_rises),        32'd64);
        check("b2b_words", 32'(rx_words - words0), 32'd2);
        check("b2b_sb",    32'(sb_q.size()),       32'd0);

        // Backpressure: third word waits until the second leaves hold
        words0 = rx_words;
        send(32'h0BAD_F00D, w);
        send(32'hCAFE_0001, w);
        send(32'h7E57_AB1E, w);
        check("bp_wait",  32'(w), 32'd127);
        wait_idle("bp_idle");
        check("bp_run",   32'(last_run),          32'd384);
        check("bp_rises", 32'(last_rises),        32'd96);
        check("bp_words", 32'(rx_words - words0), 32'd3);
        check("bp_sb",    32'(sb_q.size()),       32'd0);

        // Mid-word reset after 10 rises
        send(32'hFFFF_FFFF, w);
        n = 0;
        while (run_rises < 10 && n < 200) begin
            @(negedge aclk);
            #1;
            n++;
        end
        if (run_rises < 10) fail("mid_rst_rises");
        check("pre_rst_sclk", 32'(sclk), 32'd1);
        areset = 1'b1;
        #1;
        check("mid_rst_sclk",   32'(sclk),     32'd0);
        check("mid_rst_svalid", 32'(svalid),   32'd0);
        check("mid_rst_sdata",  32'(sdata),    32'd0);
        check("mid_rst_ready",  32'(tx_ready), 32'd0);
        repeat (2) @(negedge aclk);
        areset = 1'b0;
        repeat (4) @(negedge aclk);
        check("post_rst_svalid", 32'(svalid), 32'd0);
        check("post_rst_busy",   32'(busy),   32'd0);
        words0 = rx_words;
        send(32'h0000_0001, w);
        wait_idle("post_rst_idle");
        check("post_rst_run",   32'(last_run),          32'd128);
        check("post_rst_rises", 32'(last_rises),        32'd32);
        check("post_rst_words", 32'(rx_words - words0), 32'd1);

        // clk_div = 1 instance
        check("div1_ready", 32'(tx_ready1), 32'd1);
        tx_data1  = 32'hFFFF_0000;
        tx_valid1 = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        tx_valid1 = 1'b0;
        check("div1_svalid_E", 32'(svalid1), 32'd0);
        run1 = 0; rises1 = 0; first_rise = 0; word1 = '0; p1 = sclk1;
        for (int i = 0; i < 300; i++) begin
            @(negedge aclk);
            if (svalid1) begin
                run1++;
                if (sclk1 && !p1) begin
                    rises1++;
                    word1 = {word1[30:0], sdata1};
                    if (first_rise == 0) first_rise = run1;
                end
            end
            p1 = sclk1;
            if (run1 > 0 && !svalid1) break;
        end
        check("div1_first_rise", 32'(first_rise), 32'd2);
        check("div1_run",        32'(run1),       32'd64);
        check("div1_rises",      32'(rises1),     32'd32);
        check("div1_word",       word1,           32'hFFFF_0000);

        check("final_sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        fail("watchdog");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
